// File: rtl/mp_ctrl_pkg.sv
// mp_ctrl_pkg: shared field widths and state encoding for the motion-pipeline frame controller
package mp_ctrl_pkg;
  localparam int WIDTH_BITS = 11;
  localparam int HEIGHT_BITS = 10;
  localparam int PIX_BITS = WIDTH_BITS + HEIGHT_BITS;
  typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, DONE} state_e;
endpackage

// File: rtl/mp_pix_counter.sv
// mp_pix_counter: clearable pixel up-counter with a terminal flag at cnt == total
module mp_pix_counter #(
  parameter int W = mp_ctrl_pkg::PIX_BITS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         inc_i,
  input  logic [W-1:0] total_i,
  output logic [W-1:0] cnt_o,
  output logic         hit_o
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr_i ? '0 : inc_i ? cnt_q + W'(1) : cnt_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign cnt_o = cnt_q;
  assign hit_o = cnt_q == total_i;
endmodule

// File: rtl/mp_frame_ctrl.sv
// mp_frame_ctrl: frame sequencer aligning camera pixels with background-memory reads.
// Optional MP_BG_REFRESH_EN forces a background capture every BG_REFRESH_PERIOD frames.
module mp_frame_ctrl #(
  parameter int WIDTH_BITS        = mp_ctrl_pkg::WIDTH_BITS,
  parameter int HEIGHT_BITS       = mp_ctrl_pkg::HEIGHT_BITS,
  parameter int PIX_BITS          = WIDTH_BITS + HEIGHT_BITS,
  parameter int BG_REFRESH_PERIOD = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   bg_capture,
  input  logic [WIDTH_BITS-1:0]  cfg_width,
  input  logic [HEIGHT_BITS-1:0] cfg_height,
  input  logic [7:0]             cfg_threshold,
  input  logic                   in_valid,
  input  logic [31:0]            in_pixel,
  output logic                   in_ready,
  output logic                   mem_rd_en,
  output logic [PIX_BITS-1:0]    mem_rd_addr,
  output logic                   mp_enable,
  output logic [31:0]            mp_rbg_pixel,
  output logic                   mp_wr_background,
  output logic                   mp_last_in_frame,
  output logic [7:0]             mp_threshold,
  output logic [WIDTH_BITS-1:0]  mp_width,
  output logic [HEIGHT_BITS-1:0] mp_height,
  input  logic                   mp_pixel_valid,
  output logic                   busy,
  output logic                   frame_done,
  output logic [15:0]            frame_count
);
  import mp_ctrl_pkg::*;
  state_e                 state_q, state_d;
  logic [WIDTH_BITS-1:0]  width_q;
  logic [HEIGHT_BITS-1:0] height_q;
  logic [7:0]             thr_q;
  logic [PIX_BITS-1:0]    total_q, in_idx, out_cnt;
  logic [15:0]            frame_count_q;
  logic [31:0]            pix_q;
  logic                   bg_pending_q, bg_pending_d, frame_bg_q, enable_q, last_q;
  logic                   go, accept, last_acc, pv_inc, out_done, in_hit, out_hit, refresh_set;
  assign go       = start && state_q == IDLE && cfg_width != '0 && cfg_height != '0;
  assign in_ready = state_q == RUN && !in_hit;
  assign accept   = in_valid && in_ready;
  assign last_acc = accept && in_idx == total_q - PIX_BITS'(1);
  assign pv_inc   = mp_pixel_valid && (state_q == RUN || state_q == DRAIN);
  // the final result may arrive in the same cycle the drain check runs
  assign out_done = out_hit || (pv_inc && out_cnt == total_q - PIX_BITS'(1));
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = go ? LOAD : IDLE;
      LOAD:    state_d = RUN;
      RUN:     state_d = last_acc ? DRAIN : RUN;
      DRAIN:   state_d = out_done ? DONE : DRAIN;
      default: state_d = IDLE;
    endcase
  end
  // a capture request on the LOAD cycle survives the clear and applies to the next frame
  assign bg_pending_d = bg_capture || refresh_set || (bg_pending_q && state_q != LOAD);
`ifdef MP_BG_REFRESH_EN
  localparam int RW = BG_REFRESH_PERIOD > 1 ? $clog2(BG_REFRESH_PERIOD) : 1;
  logic [RW-1:0] refresh_q;
  assign refresh_set = state_q == DONE && refresh_q == RW'(BG_REFRESH_PERIOD - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) refresh_q <= '0;
    else if (state_q == DONE) refresh_q <= refresh_set ? '0 : refresh_q + RW'(1);
`else
  assign refresh_set = BG_REFRESH_PERIOD < 0;
`endif
  mp_pix_counter #(.W(PIX_BITS)) u_in_idx (
    .clk(clk), .rst(rst), .clr_i(state_q == LOAD), .inc_i(accept),
    .total_i(total_q), .cnt_o(in_idx), .hit_o(in_hit)
  );
  mp_pix_counter #(.W(PIX_BITS)) u_out_cnt (
    .clk(clk), .rst(rst), .clr_i(state_q == LOAD), .inc_i(pv_inc),
    .total_i(total_q), .cnt_o(out_cnt), .hit_o(out_hit)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q       <= IDLE;
      width_q       <= '0;
      height_q      <= '0;
      thr_q         <= '0;
      total_q       <= '0;
      bg_pending_q  <= 1'b1;
      frame_bg_q    <= 1'b0;
      enable_q      <= 1'b0;
      last_q        <= 1'b0;
      pix_q         <= '0;
      frame_count_q <= '0;
    end else begin
      state_q      <= state_d;
      bg_pending_q <= bg_pending_d;
      enable_q     <= accept;
      last_q       <= last_acc;
      if (go) begin
        width_q  <= cfg_width;
        height_q <= cfg_height;
        thr_q    <= cfg_threshold;
      end
      if (state_q == LOAD) begin
        total_q    <= PIX_BITS'(width_q) * PIX_BITS'(height_q);
        frame_bg_q <= bg_pending_q;
      end
      if (accept) pix_q <= in_pixel;
      if (state_q == DONE) frame_count_q <= frame_count_q + 16'd1;
    end
  assign mem_rd_en        = accept;
  assign mem_rd_addr      = accept ? in_idx : '0;
  assign mp_enable        = enable_q;
  assign mp_rbg_pixel     = pix_q;
  assign mp_last_in_frame = last_q;
  assign mp_wr_background = state_q == LOAD ? bg_pending_q : state_q != IDLE && frame_bg_q;
  assign mp_threshold     = thr_q;
  assign mp_width         = width_q;
  assign mp_height        = height_q;
  assign busy             = state_q != IDLE;
  assign frame_done       = state_q == DONE;
  assign frame_count      = frame_count_q;
endmodule
